// File: rtl/nbit_regfile_scoreboard.sv
// nbit_regfile_scoreboard
//   Register file with one write port and two combinational read ports, plus a
//   per-register pending (scoreboard) bit. Decode marks a destination pending on
//   issue. Writeback clears the bit. Reads of a pending operand raise busy/stall.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   read_sel_1/2                read addresses
//   read_data_1/2               combinational read data (with optional bypass)
//   RegWrite, write_address,
//   write_data                  writeback port
//   issue_en, issue_address     marks a destination register pending
//   busy_1/2, stall             operand-pending indications for the read ports
//   pending_count               registered population count of pending bits
module nbit_regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_sel_1,
  input  logic [ADDR_WIDTH-1:0] read_sel_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [Depth];
  logic [Depth-1:0]      pending;
  logic [Depth-1:0]      pending_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  write_ok;
  logic                  issue_ok;

  // Writes and issues to the hardwired zero register are dropped.
  assign write_ok = RegWrite && !((ZERO_REG != 0) && (write_address == '0));
  assign issue_ok = issue_en && !((ZERO_REG != 0) && (issue_address == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < Depth; r++) begin
        regs[r] <= '0;
      end
    end else if (write_ok) begin
      regs[write_address] <= write_data;
    end
  end

  // Issue takes priority over writeback: a new producer keeps the bit set.
  always_comb begin
    pending_next = pending;
    for (int unsigned r = 0; r < Depth; r++) begin
      if (issue_ok && (issue_address == ADDR_WIDTH'(r))) begin
        pending_next[r] = 1'b1;
      end else if (RegWrite && (write_address == ADDR_WIDTH'(r))) begin
        pending_next[r] = 1'b0;
      end
    end
  end

  always_comb begin
    count_next = '0;
    for (int unsigned r = 0; r < Depth; r++) begin
      count_next = count_next + {{ADDR_WIDTH{1'b0}}, pending_next[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pending_next;
      pending_count <= count_next;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] sel);
    if ((ZERO_REG != 0) && (sel == '0)) begin
      return '0;
    end else if ((BYPASS != 0) && RegWrite && (write_address == sel)) begin
      return write_data;
    end else begin
      return regs[sel];
    end
  endfunction

  // A same-cycle writeback hides the hazard only if it is not re-issued in the
  // same cycle, since the new producer's result is still outstanding.
  function automatic logic busy_of(input logic [ADDR_WIDTH-1:0] sel);
    if ((ZERO_REG != 0) && (sel == '0)) begin
      return 1'b0;
    end else if ((BYPASS != 0) && RegWrite && (write_address == sel) &&
                 !(issue_en && (issue_address == sel))) begin
      return 1'b0;
    end else begin
      return pending[sel];
    end
  endfunction

  always_comb begin
    read_data_1 = read_port(read_sel_1);
    read_data_2 = read_port(read_sel_2);
    busy_1      = busy_of(read_sel_1);
    busy_2      = busy_of(read_sel_2);
    stall       = busy_1 | busy_2;
  end

endmodule

// File: doc/nbit_regfile_scoreboard.md
Name: nbit_regfile_scoreboard

Overview:
- Parametrised successor to the single-write, two-read register file in the datapath.
- Adds asynchronous clear, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register pending (scoreboard) bit: set when an instruction issues to a destination, cleared on writeback.
- Sits between decode (read/issue) and writeback; drives the pipeline stall for read-after-write hazards.

Parameters:
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, select width; depth = 2**ADDR_WIDTH
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and issues
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- read_sel_1  input  ADDR_WIDTH  read port 1 address
- read_sel_2  input  ADDR_WIDTH  read port 2 address
- read_data_1  output  DATA_WIDTH  read port 1 data (combinational)
- read_data_2  output  DATA_WIDTH  read port 2 data (combinational)
- RegWrite  input  1  writeback enable
- write_address  input  ADDR_WIDTH  writeback destination
- write_data  input  DATA_WIDTH  writeback data
- issue_en  input  1  mark issue_address pending
- issue_address  input  ADDR_WIDTH  destination of issuing instruction
- busy_1  output  1  read port 1 operand pending
- busy_2  output  1  read port 2 operand pending
- stall  output  1  busy_1 OR busy_2
- pending_count  output  ADDR_WIDTH+1  registered count of set pending bits

Behaviour:
- Reset (rst_n low, asynchronous, no clock required):
  - all registers, pending bits and pending_count go to 0.
  - Consequently read_data_1/2 = 0 and busy_1/2 = stall = 0.
  - Reset mid-operation discards any writes and issues in flight.
  - Release is synchronous to the next rising edge; the first edge with rst_n high performs normal updates.
- Write:
  - at posedge, if RegWrite and not (ZERO_REG and write_address == 0), reg[write_address] <= write_data.
  - One-cycle latency without bypass.
- Read:
  - combinational from the array.
  - If ZERO_REG and sel == 0, data = 0 regardless of array contents.
  - If BYPASS and RegWrite and write_address == sel (and not the zero register), data = write_data.
  - Otherwise data = reg[sel]. Without bypass, old data is returned in the write cycle.
- Pending bit update at posedge, per register r:
  - set if issue_en and issue_address == r;
  - else cleared if RegWrite and write_address == r;
  - else held.
  - Issue and writeback to the same r in the same cycle: the bit stays set (the new producer wins); register data is still written.
  - ZERO_REG: register 0's pending bit is never set.
  - Issue to an already-pending register: bit stays set, no count change.
  - Writeback to a non-pending register: data is written, no count change.
- busy_n = pending[sel_n], except:
  - 0 when BYPASS and RegWrite and write_address == sel_n and not (issue_en and issue_address == sel_n) — the value is forwarded this cycle;
  - 0 for register 0 when ZERO_REG.
- stall = busy_1 | busy_2, combinational. The block never blocks issue_en; decode gates issue with stall.
- pending_count = population count of pending bits, updated on the same edge as the bits.
  - Range is 0..2**ADDR_WIDTH; it never wraps because ADDR_WIDTH+1 bits hold the full depth.

Test Plan:
- Reset: pulse rst_n low mid-cycle after writing reg5 = 0x1234 -> read_sel_1 = 5 gives 0 immediately, pending_count = 0, stall = 0.
- Write/read: write reg7 = 0xDEADBEEF, read both ports at 7 next cycle -> both 0xDEADBEEF.
- Same-cycle bypass: BYPASS = 1, write reg3 = 0xA5 while read_sel_2 = 3 -> read_data_2 = 0xA5 in that cycle.
  - Same case with BYPASS = 0 -> old value, 0xA5 on the following cycle.
- Zero register: ZERO_REG = 1, write reg0 = 0xFFFF and issue reg0 -> read 0, busy 0, pending_count 0.
- Scoreboard:
  - issue reg9, next cycle read_sel_1 = 9 -> busy_1 = stall = 1, pending_count = 1;
  - writeback reg9 = 0x42 -> busy_1 = 0 in that cycle (BYPASS = 1) with data 0x42; pending_count = 0 after the edge.
- Simultaneous: issue reg4 and writeback reg4 = 0x10 in one cycle -> reg4 = 0x10, pending[4] stays 1, pending_count unchanged.
  - Issue all 31 non-zero registers -> pending_count = 31.
